spi_xfer_ctrl: RTL

- Transaction controller for the SPI master. It sequences one full-duplex, fixed-width SPI transfer in mode 0 (CPOL=0, CPHA=0).
- It gates and re-phases the SCK clock divider and uses the divider's half-period tick pulses to drive SCK, MOSI and CS_n and to sample MISO.
- It exposes a start/busy/done handshake to the host-side logic.

---
 rtl/spi_xfer_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI transfer sequencer: CS setup, 2*P_DATA_W tick-driven SCK edges, CS hold, done pulse; all outputs registered.
// SPI_LSB_FIRST_EN selects LSB-first shifting; start is accepted only in IDLE (incl. the done cycle), never queued.
module spi_xfer_ctrl #(
    parameter int P_DATA_W   = 8,
    parameter int P_CS_SETUP = 1,
    parameter int P_CS_HOLD  = 1
) (
    input  logic                clk_100,
    input  logic                s_rst,
    input  logic                start,
    input  logic [P_DATA_W-1:0] tx_data,
    output logic                busy,
    output logic                done,
    output logic [P_DATA_W-1:0] rx_data,
    input  logic                tick,
    output logic                div_hold,
    output logic                div_clr,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic                spi_cs_n
);

    localparam int EW   = $clog2(2 * P_DATA_W) + 1;
    localparam int TMAX = (P_CS_SETUP > P_CS_HOLD) ? P_CS_SETUP : P_CS_HOLD;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * P_DATA_W - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(P_CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(P_CS_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [P_DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [P_DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [P_DATA_W-1:0] rx_data_q, rx_data_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                hold_q, hold_d;
    logic                clr_q, clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        tcnt_d    = tcnt_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        hold_d    = hold_q;
        clr_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    clr_d   = 1'b1;
                    hold_d  = 1'b0;
                    sck_d   = 1'b0;
                    edge_d  = '0;
                    tcnt_d  = '0;
                    rx_sh_d = '0;
                    // First bit goes straight to MOSI; the shifter keeps only the remaining bits.
`ifdef SPI_LSB_FIRST_EN
                    mosi_d  = tx_data[0];
                    tx_sh_d = {1'b0, tx_data[P_DATA_W-1:1]};
`else
                    mosi_d  = tx_data[P_DATA_W-1];
                    tx_sh_d = {tx_data[P_DATA_W-2:0], 1'b0};
`endif
                end
            end

            S_SETUP: begin
                if (tick) begin
                    if (tcnt_q == SETUP_LAST) begin
                        state_d = S_XFER;
                        tcnt_d  = '0;
                        edge_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end

            S_XFER: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EW'(1);
                    if (!edge_q[0]) begin
                        // Rising edge: MISO is captured on the same cycle the tick arrives.
`ifdef SPI_LSB_FIRST_EN
                        rx_sh_d = {spi_miso, rx_sh_q[P_DATA_W-1:1]};
`else
                        rx_sh_d = {rx_sh_q[P_DATA_W-2:0], spi_miso};
`endif
                    end else if (edge_q == EDGE_LAST) begin
                        state_d = S_HOLD;
                        tcnt_d  = '0;
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        mosi_d  = tx_sh_q[0];
                        tx_sh_d = {1'b0, tx_sh_q[P_DATA_W-1:1]};
`else
                        mosi_d  = tx_sh_q[P_DATA_W-1];
                        tx_sh_d = {tx_sh_q[P_DATA_W-2:0], 1'b0};
`endif
                    end
                end
            end

            S_HOLD: begin
                if (tick) begin
                    if (tcnt_q == HOLD_LAST) begin
                        state_d   = S_IDLE;
                        cs_n_d    = 1'b1;
                        hold_d    = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                        tcnt_d    = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q   <= S_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            tcnt_q    <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            hold_q    <= 1'b1;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            tcnt_q    <= tcnt_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            hold_q    <= hold_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign div_hold = hold_q;
    assign div_clr  = clr_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule
